// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the iterative binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Nibble value shown in place of a suppressed leading zero digit.
  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Double-dabble pre-shift correction: digits 5..9 become 8..12 so the
  // following shift carries into the next decade.
  function automatic logic [3:0] dabble_adjust(input logic [3:0] digit);
    return (digit > 4'd4) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Combinational per-digit add-3 correction used by the double-dabble loop.
// Plain 4-bit add; no carry into the neighbouring digit.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = dabble_adjust(digit);

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter with valid/ready handshakes.
// One input bit is consumed per cycle; all digits are adjusted in parallel.
// Optional two's-complement input (sign + magnitude result), sticky overflow
// with saturation to all nines.
// Build option: define BIN2BCD_LZ_BLANK_EN to replace leading zero digits of a
// non-saturated result with 4'hF (digit 0 is never blanked).
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_WIDTH  = 8,
  parameter int unsigned DEC_DIGITS = 3,
  parameter int unsigned SIGNED     = 0
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [BIN_WIDTH-1:0]    DataBin,
  input  logic                    In_valid,
  output logic                    In_ready,
  output logic [DEC_DIGITS*4-1:0] DataBCD,
  output logic                    Sign,
  output logic                    Overflow,
  output logic                    Out_valid,
  input  logic                    Out_ready
);

  localparam int unsigned BCD_W = DEC_DIGITS * 4;
  localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_WIDTH - 1);

  state_t               state_q;
  logic [BIN_WIDTH-1:0] shift_q;
  logic [BCD_W-1:0]     bcd_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 neg;
  logic [BIN_WIDTH-1:0] mag;
  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W-1:0]     bcd_next;
  logic                 ovf_next;
  logic [BCD_W-1:0]     result;

  // Leading-zero suppression of a finished BCD value (identity when disabled).
  function automatic logic [BCD_W-1:0] lz_blank(input logic [BCD_W-1:0] bcd);
    logic seen;
    lz_blank = bcd;
    seen     = 1'b0;
`ifdef BIN2BCD_LZ_BLANK_EN
    for (int i = int'(DEC_DIGITS) - 1; i > 0; i--) begin
      if (!seen && bcd[4*i +: 4] == 4'd0) begin
        lz_blank[4*i +: 4] = BCD_BLANK;
      end else begin
        seen = 1'b1;
      end
    end
`endif
  endfunction

  for (genvar g = 0; g < DEC_DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .digit    (bcd_q[4*g +: 4]),
      .adjusted (bcd_adj[4*g +: 4])
    );
  end

  // Magnitude of the operand; negative only for signed builds with MSB set.
  assign neg = (SIGNED != 0) && DataBin[BIN_WIDTH-1];
  assign mag = neg ? -DataBin : DataBin;

  // {bcd, shift} shifted left after adjust; the bit leaving the BCD MSB is overflow.
  assign bcd_next = {bcd_adj[BCD_W-2:0], shift_q[BIN_WIDTH-1]};
  assign ovf_next = Overflow | bcd_adj[BCD_W-1];

  // Presented result for the final conversion step: saturated or formatted.
  always_comb begin
    result = lz_blank(bcd_next);
    if (ovf_next) begin
      result = {DEC_DIGITS{4'h9}};
    end
  end

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      In_ready  <= 1'b1;
      Out_valid <= 1'b0;
      DataBCD   <= '0;
      Sign      <= 1'b0;
      Overflow  <= 1'b0;
      shift_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (In_valid) begin
            shift_q  <= mag;
            Sign     <= neg;
            bcd_q    <= '0;
            Overflow <= 1'b0;
            cnt_q    <= '0;
            DataBCD  <= '0;
            In_ready <= 1'b0;
            state_q  <= CONV;
          end
        end
        CONV: begin
          bcd_q    <= bcd_next;
          shift_q  <= shift_q << 1;
          Overflow <= ovf_next;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            DataBCD   <= result;
            Out_valid <= 1'b1;
            state_q   <= HOLD;
          end
        end
        HOLD: begin
          if (Out_ready) begin
            Out_valid <= 1'b0;
            In_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq. Three instances share clock and reset:
// ch0 = 8-bit unsigned / 3 digits, ch1 = 8-bit unsigned / 2 digits,
// ch2 = 8-bit signed / 3 digits. Expected results are queued at issue time and
// popped by a monitor whenever a channel completes an output handshake.
module tb_bin2bcd_seq;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [7:0] din [3];
  logic [2:0] in_valid;
  logic [2:0] out_ready;
  logic [2:0] in_rdy;
  logic [2:0] out_valid;
  logic [2:0] sign;
  logic [2:0] ovf;
  logic [11:0] bcd0;
  logic [7:0]  bcd1;
  logic [11:0] bcd2;

  int vectors = 0;
  int miscompares = 0;
  bit bp_rand = 1'b0;

  // Entry layout: {channel[1:0], sign, overflow, bcd[11:0]}
  logic [15:0] exp_q[$];

  always #5 Clk = ~Clk;

  bin2bcd_seq #(.BIN_WIDTH(8), .DEC_DIGITS(3), .SIGNED(0)) u_dut0 (
    .Clk(Clk), .Rst_n(Rst_n), .DataBin(din[0]), .In_valid(in_valid[0]),
    .In_ready(in_rdy[0]), .DataBCD(bcd0), .Sign(sign[0]), .Overflow(ovf[0]),
    .Out_valid(out_valid[0]), .Out_ready(out_ready[0])
  );

  bin2bcd_seq #(.BIN_WIDTH(8), .DEC_DIGITS(2), .SIGNED(0)) u_dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .DataBin(din[1]), .In_valid(in_valid[1]),
    .In_ready(in_rdy[1]), .DataBCD(bcd1), .Sign(sign[1]), .Overflow(ovf[1]),
    .Out_valid(out_valid[1]), .Out_ready(out_ready[1])
  );

  bin2bcd_seq #(.BIN_WIDTH(8), .DEC_DIGITS(3), .SIGNED(1)) u_dut2 (
    .Clk(Clk), .Rst_n(Rst_n), .DataBin(din[2]), .In_valid(in_valid[2]),
    .In_ready(in_rdy[2]), .DataBCD(bcd2), .Sign(sign[2]), .Overflow(ovf[2]),
    .Out_valid(out_valid[2]), .Out_ready(out_ready[2])
  );

  function automatic logic [11:0] bcd_of(input int ch);
    case (ch)
      0:       return bcd0;
      1:       return {4'h0, bcd1};
      default: return bcd2;
    endcase
  endfunction

  // Reference: decimal digits by division, saturation and blanking by value range.
  function automatic logic [13:0] ref_model(input int ch, input logic [7:0] v);
    int         digits;
    bit         neg;
    int         mag;
    int         lim;
    int         m;
    int         p;
    logic [11:0] b;
    bit         over;
    digits = (ch == 1) ? 2 : 3;
    neg    = (ch == 2) && v[7];
    mag    = neg ? 256 - int'(v) : int'(v);
    lim    = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    over = (mag >= lim);
    b    = '0;
    if (over) begin
      for (int i = 0; i < digits; i++) b[4*i +: 4] = 4'h9;
    end else begin
      m = mag;
      for (int i = 0; i < digits; i++) begin
        b[4*i +: 4] = 4'(m % 10);
        m = m / 10;
      end
`ifdef BIN2BCD_LZ_BLANK_EN
      p = 10;
      for (int i = 1; i < digits; i++) begin
        if (mag < p) b[4*i +: 4] = 4'hF;
        p = p * 10;
      end
`else
      p = 0;
`endif
    end
    return {neg, over, b};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the accepting posedge.
  task automatic issue(input int ch, input logic [7:0] v);
    int t;
    t = 0;
    while (!in_rdy[ch] && t < 200) begin
      if (bp_rand) out_ready = 3'($urandom);
      @(posedge Clk);
      #1;
      t++;
    end
    if (t >= 200) begin
      chk($sformatf("ch%0d issue timeout", ch), 32'(in_rdy[ch]), 32'd1);
    end else begin
      din[ch]      = v;
      in_valid[ch] = 1'b1;
      exp_q.push_back({2'(ch), ref_model(ch, v)});
      @(posedge Clk);
      #1;
      in_valid[ch] = 1'b0;
      if (bp_rand) out_ready = 3'($urandom);
    end
  endtask

  task automatic drain();
    int t;
    bp_rand   = 1'b0;
    out_ready = 3'b111;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge Clk);
      #1;
      t++;
    end
    chk("drain scoreboard empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every output handshake consumes the oldest expectation for that channel.
  always @(negedge Clk) begin : monitor
    int          idx;
    logic [13:0] got;
    logic [13:0] want;
    if (Rst_n === 1'b1) begin
      for (int c = 0; c < 3; c++) begin
        if (out_valid[c] && out_ready[c]) begin
          idx = -1;
          for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && int'(exp_q[i][15:14]) == c) idx = i;
          end
          got = {sign[c], ovf[c], bcd_of(c)};
          vectors++;
          if (idx < 0) begin
            miscompares++;
            $display("FAIL ch%0d unexpected result: got sign=%0b ovf=%0b bcd=%h, want none",
                     c, got[13], got[12], got[11:0]);
          end else begin
            want = exp_q[idx][13:0];
            exp_q.delete(idx);
            if (got !== want) begin
              miscompares++;
              $display("FAIL ch%0d result: got sign=%0b ovf=%0b bcd=%h, want sign=%0b ovf=%0b bcd=%h",
                       c, got[13], got[12], got[11:0], want[13], want[12], want[11:0]);
            end
          end
        end
      end
    end
  end

  initial begin
    int          k;
    logic [11:0] snap;

    Rst_n     = 1'b0;
    in_valid  = 3'b000;
    out_ready = 3'b111;
    for (int i = 0; i < 3; i++) din[i] = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset in_ready", 32'(in_rdy), 32'h7);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset sign/ovf", 32'({sign, ovf}), 32'h0);
    chk("reset bcd", 32'({bcd0, bcd1, bcd2}), 32'h0);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    // Latency: Out_valid rises 8 cycles after the accepting edge.
    issue(0, 8'd255);
    k = 1;
    @(posedge Clk);
    #1;
    while (!out_valid[0] && k < 20) begin
      @(posedge Clk);
      #1;
      k++;
    end
    chk("ch0 latency cycles", 32'(k), 32'd8);
    drain();

    // Full unsigned sweep and random operands under random backpressure.
    bp_rand = 1'b1;
    for (int v = 0; v < 256; v++) issue(0, 8'(v));
    for (int i = 0; i < 40; i++) issue(0, 8'($urandom));
    drain();

    // Two-digit instance: overflow boundary.
    issue(1, 8'd123);
    issue(1, 8'd99);
    issue(1, 8'd100);
    bp_rand = 1'b1;
    for (int i = 0; i < 40; i++) issue(1, 8'($urandom));
    drain();

    // Signed instance: corner values then random.
    issue(2, 8'h80);
    issue(2, 8'hFF);
    issue(2, 8'h00);
    issue(2, 8'h7F);
    bp_rand = 1'b1;
    for (int i = 0; i < 40; i++) issue(2, 8'($urandom));
    drain();

    // Backpressure: result held for 5 cycles, In_valid pulses ignored.
    out_ready[0] = 1'b0;
    issue(0, 8'd77);
    k = 0;
    while (!out_valid[0] && k < 20) begin
      @(posedge Clk);
      #1;
      k++;
    end
    chk("bp out_valid reached", 32'(out_valid[0]), 32'd1);
    snap = bcd0;
    for (int i = 0; i < 5; i++) begin
      din[0]      = 8'($urandom);
      in_valid[0] = ~in_valid[0];
      @(posedge Clk);
      #1;
      chk("bp bcd stable", 32'(bcd0), 32'(snap));
      chk("bp in_ready low", 32'(in_rdy[0]), 32'd0);
      chk("bp out_valid held", 32'(out_valid[0]), 32'd1);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge Clk);
    #1;
    chk("bp in_ready after handshake", 32'(in_rdy[0]), 32'd1);
    chk("bp out_valid after handshake", 32'(out_valid[0]), 32'd0);
    repeat (12) @(posedge Clk);
    #1;
    chk("bp no spurious result", 32'(out_valid[0]), 32'd0);
    drain();

    // Reset on the 4th conversion cycle discards the pending result.
    issue(0, 8'd200);
    repeat (3) begin
      @(posedge Clk);
      #1;
    end
    Rst_n = 1'b0;
    @(posedge Clk);
    #1;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i][15:14] == 2'd0) exp_q.delete(i);
    end
    chk("mid-reset in_ready", 32'(in_rdy[0]), 32'd1);
    chk("mid-reset out_valid", 32'(out_valid[0]), 32'd0);
    chk("mid-reset outputs", 32'({bcd0, sign[0], ovf[0]}), 32'd0);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    issue(0, 8'd42);
    issue(0, 8'd7);
    issue(0, 8'd105);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
